// File: rtl/oldland_bus_arbiter_pkg.sv
// Shared definitions for the oldland bus arbiter: FSM encoding, grant identifiers and
// the default abort timeout.
package oldland_bus_defs;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    function automatic state_t busy_state(input grant_t grant);
        return (grant == GRANT_D) ? D_BUSY : I_BUSY;
    endfunction

endpackage

// File: rtl/oldland_bus_arbiter_if.sv
// Bus bundle between the instruction/data requesters, the arbiter and the shared memory port.
// The arbiter uses the slave modport; the requester/memory side uses master.
interface oldland_bus_arbiter_if;

    logic        i_access;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic        i_ack;
    logic        i_error;

    logic        d_access;
    logic [31:0] d_addr;
    logic [3:0]  d_bytesel;
    logic        d_wr_en;
    logic [31:0] d_wr_val;
    logic [31:0] d_data;
    logic        d_ack;
    logic        d_error;

    logic        m_access;
    logic [31:0] m_addr;
    logic [3:0]  m_bytesel;
    logic        m_wr_en;
    logic [31:0] m_wr_val;
    logic [31:0] m_data;
    logic        m_ack;
    logic        m_error;

    modport slave (
        input  i_access, i_addr,
        output i_data, i_ack, i_error,
        input  d_access, d_addr, d_bytesel, d_wr_en, d_wr_val,
        output d_data, d_ack, d_error,
        output m_access, m_addr, m_bytesel, m_wr_en, m_wr_val,
        input  m_data, m_ack, m_error
    );

    modport master (
        output i_access, i_addr,
        input  i_data, i_ack, i_error,
        output d_access, d_addr, d_bytesel, d_wr_en, d_wr_val,
        input  d_data, d_ack, d_error,
        input  m_access, m_addr, m_bytesel, m_wr_en, m_wr_val,
        output m_data, m_ack, m_error
    );

endinterface

// File: rtl/oldland_bus_timeout.sv
// Busy-cycle counter for the arbiter; expired flags the TIMEOUT_CYCLES-th consecutive
// busy cycle that has seen no memory response.
module oldland_bus_timeout
    import oldland_bus_defs::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Counter holds the busy cycles already elapsed, so the current cycle is count+1.
    assign expired = enable && (r_count == LAST_COUNT);

endmodule

// File: rtl/oldland_bus_arbiter.sv
// Two-requester (instruction/data) arbiter onto a single memory port with alternating
// priority on ties, back-to-back handover and a busy timeout that aborts hung accesses.
module oldland_bus_arbiter
    import oldland_bus_defs::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    oldland_bus_arbiter_if.slave bus
);

    state_t      r_state;
    state_t      w_next_state;
    grant_t      r_last_grant;
    grant_t      w_grant_id;
    logic        w_grant;
    logic        w_resp;
    logic        w_busy;
    logic        w_expired;

    logic [31:0] r_m_addr;
    logic [3:0]  r_m_bytesel;
    logic        r_m_wr_en;
    logic [31:0] r_m_wr_val;

    assign w_resp = bus.m_ack | bus.m_error;
    assign w_busy = (r_state != IDLE);

    oldland_bus_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_grant),
        .enable (w_busy && !w_resp),
        .expired(w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_grant_id   = GRANT_I;
        unique case (r_state)
            IDLE: begin
                if (bus.i_access && bus.d_access) begin
                    w_grant    = 1'b1;
                    w_grant_id = (r_last_grant == GRANT_I) ? GRANT_D : GRANT_I;
                end else if (bus.d_access) begin
                    w_grant    = 1'b1;
                    w_grant_id = GRANT_D;
                end else if (bus.i_access) begin
                    w_grant    = 1'b1;
                    w_grant_id = GRANT_I;
                end
            end
            I_BUSY: begin
                // Only a real response hands over directly; a timeout always rests in IDLE.
                if (w_resp) begin
                    w_next_state = IDLE;
                    if (bus.d_access) begin
                        w_grant    = 1'b1;
                        w_grant_id = GRANT_D;
                    end
                end else if (w_expired) begin
                    w_next_state = IDLE;
                end
            end
            D_BUSY: begin
                if (w_resp) begin
                    w_next_state = IDLE;
                    if (bus.i_access) begin
                        w_grant    = 1'b1;
                        w_grant_id = GRANT_I;
                    end
                end else if (w_expired) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        if (w_grant) begin
            w_next_state = busy_state(w_grant_id);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= GRANT_I;
            r_m_addr     <= '0;
            r_m_bytesel  <= '0;
            r_m_wr_en    <= 1'b0;
            r_m_wr_val   <= '0;
        end else if (w_grant) begin
            r_last_grant <= w_grant_id;
            if (w_grant_id == GRANT_D) begin
                r_m_addr    <= bus.d_addr;
                r_m_bytesel <= bus.d_bytesel;
                r_m_wr_en   <= bus.d_wr_en;
                r_m_wr_val  <= bus.d_wr_val;
            end else begin
                r_m_addr    <= bus.i_addr;
                r_m_bytesel <= 4'hf;
                r_m_wr_en   <= 1'b0;
                r_m_wr_val  <= '0;
            end
        end
    end

    always_comb begin
        bus.m_access  = w_busy;
        bus.m_addr    = r_m_addr;
        bus.m_bytesel = r_m_bytesel;
        bus.m_wr_en   = r_m_wr_en;
        bus.m_wr_val  = r_m_wr_val;

        bus.i_data    = bus.m_data;
        bus.d_data    = bus.m_data;

        // Simultaneous ack+error is reported as an error only.
        bus.i_ack     = (r_state == I_BUSY) && bus.m_ack && !bus.m_error;
        bus.i_error   = (r_state == I_BUSY) && (bus.m_error || w_expired);
        bus.d_ack     = (r_state == D_BUSY) && bus.m_ack && !bus.m_error;
        bus.d_error   = (r_state == D_BUSY) && (bus.m_error || w_expired);
    end

endmodule

// File: tb/tb_oldland_bus_arbiter.sv
// Randomised and directed bench for oldland_bus_arbiter: a transaction-level model predicts
// memory grants and requester completions, a monitor checks them against the DUT.
module tb_oldland_bus_arbiter;

    localparam int TO       = 4;
    localparam int OWN_NONE = 0;
    localparam int OWN_I    = 1;
    localparam int OWN_D    = 2;

    typedef struct {
        int          cyc;
        bit          is_i;
        logic [31:0] addr;
        logic [3:0]  bs;
        logic        we;
        logic [31:0] wv;
    } req_t;

    typedef struct {
        int          cyc;
        bit          is_i;
        logic [3:0]  vec;
        logic [31:0] data;
    } resp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    req_t  exp_req[$];
    resp_t exp_resp[$];

    // Reference model state
    int owner     = OWN_NONE;
    int last      = OWN_I;
    int busy_cyc  = 0;
    int lat       = 0;
    int kind      = 0;
    int n_grants  = 0;
    bit done_i    = 0;
    bit done_d    = 0;

    // Stimulus knobs
    bit rand_mode  = 0;
    bit keep_i     = 0;
    bit keep_d     = 0;
    bit idle_noise = 0;
    int f_lat      = -1;
    int f_kind     = -1;

    oldland_bus_arbiter_if bus_if ();

    oldland_bus_arbiter #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic new_i();
        bus_if.i_access = 1'b1;
        bus_if.i_addr   = $urandom;
    endtask

    task automatic new_d();
        bus_if.d_access  = 1'b1;
        bus_if.d_addr    = $urandom;
        bus_if.d_bytesel = 4'($urandom_range(1, 15));
        bus_if.d_wr_en   = 1'($urandom_range(0, 1));
        bus_if.d_wr_val  = $urandom;
    endtask

    // Settle on the far side of a rising edge before changing requests by hand.
    task automatic setup_wait();
        @(posedge clk);
        #1;
    endtask

    // One cycle: drive inputs at the falling edge and predict what the next rising edge does.
    task automatic step();
        bit    completed;
        bit    real_resp;
        bit    is_err;
        int    nxt;
        req_t  rq;
        resp_t rs;
        @(negedge clk);
        if (done_i) begin
            done_i = 0;
            if (rand_mode ? ($urandom_range(0, 1) == 1) : keep_i) new_i();
            else bus_if.i_access = 1'b0;
        end
        if (done_d) begin
            done_d = 0;
            if (rand_mode ? ($urandom_range(0, 1) == 1) : keep_d) new_d();
            else bus_if.d_access = 1'b0;
        end
        if (rand_mode) begin
            if (!bus_if.i_access && $urandom_range(0, 3) == 0) new_i();
            if (!bus_if.d_access && $urandom_range(0, 3) == 0) new_d();
        end
        bus_if.m_ack   = 1'b0;
        bus_if.m_error = 1'b0;
        bus_if.m_data  = $urandom;
        completed = 0;
        real_resp = 0;
        if (owner == OWN_NONE) begin
            if (idle_noise) begin
                bus_if.m_ack   = 1'($urandom_range(0, 1));
                bus_if.m_error = 1'($urandom_range(0, 1));
            end
        end else begin
            busy_cyc++;
            if (busy_cyc == lat) begin
                completed      = 1;
                real_resp      = 1;
                bus_if.m_ack   = (kind != 1);
                bus_if.m_error = (kind != 0);
            end else if (busy_cyc == TO) begin
                completed = 1;
            end
            if (completed) begin
                is_err  = !(real_resp && kind == 0);
                rs.cyc  = cyc;
                rs.is_i = (owner == OWN_I);
                rs.data = bus_if.m_data;
                if (owner == OWN_I) rs.vec = is_err ? 4'b0100 : 4'b1000;
                else rs.vec = is_err ? 4'b0001 : 4'b0010;
                exp_resp.push_back(rs);
                if (owner == OWN_I) done_i = 1;
                else done_d = 1;
            end
        end
        nxt = owner;
        if (owner == OWN_NONE) begin
            if (bus_if.i_access && bus_if.d_access) nxt = (last == OWN_I) ? OWN_D : OWN_I;
            else if (bus_if.d_access) nxt = OWN_D;
            else if (bus_if.i_access) nxt = OWN_I;
        end else if (completed) begin
            nxt = OWN_NONE;
            if (real_resp) begin
                if (owner == OWN_I && bus_if.d_access) nxt = OWN_D;
                else if (owner == OWN_D && bus_if.i_access) nxt = OWN_I;
            end
        end
        if (nxt != OWN_NONE && (owner == OWN_NONE || completed)) begin
            rq.cyc  = cyc + 1;
            rq.is_i = (nxt == OWN_I);
            rq.addr = rq.is_i ? bus_if.i_addr : bus_if.d_addr;
            rq.bs   = rq.is_i ? 4'hf : bus_if.d_bytesel;
            rq.we   = rq.is_i ? 1'b0 : bus_if.d_wr_en;
            rq.wv   = bus_if.d_wr_val;
            exp_req.push_back(rq);
            last     = nxt;
            busy_cyc = 0;
            n_grants++;
            lat  = (f_lat > 0) ? f_lat : int'($urandom_range(1, 6));
            kind = (f_kind >= 0) ? f_kind : int'($urandom_range(0, 2));
        end
        owner = nxt;
    endtask

    task automatic drain();
        int n = 0;
        while ((owner != OWN_NONE || bus_if.i_access || bus_if.d_access) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: owner %0d still busy after %0d cycles", owner, n);
        end
        step();
        step();
    endtask

    // Monitor: compares every new memory transaction and every requester completion.
    initial begin
        logic       prev_acc;
        logic       prev_done;
        logic [3:0] vec;
        req_t       rq;
        resp_t      rs;
        prev_acc  = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            vec = {bus_if.i_ack, bus_if.i_error, bus_if.d_ack, bus_if.d_error};
            if (bus_if.m_access && (!prev_acc || prev_done)) begin
                if (exp_req.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_request at cycle %0d: addr %0h, none expected",
                             cyc, bus_if.m_addr);
                end else begin
                    rq = exp_req.pop_front();
                    chk("req_cycle", 64'(cyc), 64'(rq.cyc));
                    chk("req_addr", 64'(bus_if.m_addr), 64'(rq.addr));
                    chk("req_bytesel", 64'(bus_if.m_bytesel), 64'(rq.bs));
                    chk("req_wr_en", 64'(bus_if.m_wr_en), 64'(rq.we));
                    if (!rq.is_i) chk("req_wr_val", 64'(bus_if.m_wr_val), 64'(rq.wv));
                end
            end
            if (vec != 4'b0000) begin
                if (exp_resp.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_response at cycle %0d: got %b, none expected",
                             cyc, vec);
                end else begin
                    rs = exp_resp.pop_front();
                    chk("resp_cycle", 64'(cyc), 64'(rs.cyc));
                    chk("resp_ack_err", 64'(vec), 64'(rs.vec));
                    chk("resp_data", 64'(rs.is_i ? bus_if.i_data : bus_if.d_data), 64'(rs.data));
                end
            end
            prev_acc  = bus_if.m_access;
            prev_done = (vec != 4'b0000);
        end
    end

    initial begin
        int start;
        rst_n            = 1'b0;
        bus_if.i_access  = 1'b0;
        bus_if.i_addr    = '0;
        bus_if.d_access  = 1'b0;
        bus_if.d_addr    = '0;
        bus_if.d_bytesel = '0;
        bus_if.d_wr_en   = 1'b0;
        bus_if.d_wr_val  = '0;
        bus_if.m_data    = 32'h1234_5678;
        bus_if.m_ack     = 1'b1;
        bus_if.m_error   = 1'b1;

        // Reset state, with memory responses asserted throughout
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_m_access", 64'(bus_if.m_access), 64'd0);
        chk("rst_m_addr", 64'(bus_if.m_addr), 64'd0);
        chk("rst_m_bytesel", 64'(bus_if.m_bytesel), 64'd0);
        chk("rst_m_wr_en", 64'(bus_if.m_wr_en), 64'd0);
        chk("rst_m_wr_val", 64'(bus_if.m_wr_val), 64'd0);
        chk("rst_acks_errs", 64'({bus_if.i_ack, bus_if.i_error, bus_if.d_ack, bus_if.d_error}),
            64'd0);
        bus_if.m_ack   = 1'b0;
        bus_if.m_error = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Both rise together after reset: D first, then I back-to-back
        f_lat  = 2;
        f_kind = 0;
        new_i();
        new_d();
        drain();

        // Single data write acknowledged on the 3rd busy cycle
        setup_wait();
        f_lat            = 3;
        f_kind           = 0;
        bus_if.d_access  = 1'b1;
        bus_if.d_addr    = 32'h0000_0100;
        bus_if.d_bytesel = 4'hf;
        bus_if.d_wr_en   = 1'b1;
        bus_if.d_wr_val  = 32'hdead_beef;
        drain();

        // Both held for six transactions, ack on every 2nd busy cycle
        setup_wait();
        start  = n_grants;
        keep_i = 1;
        keep_d = 1;
        f_lat  = 2;
        f_kind = 0;
        new_i();
        new_d();
        while (n_grants - start < 6 && n_grants - start >= 0 && cyc < 100000) step();
        keep_i = 0;
        keep_d = 0;
        drain();

        // Timeout on a fetch, then response arriving in the timeout cycle
        setup_wait();
        f_lat = 100;
        new_i();
        drain();
        setup_wait();
        f_lat  = TO;
        f_kind = 0;
        new_i();
        drain();

        // ack+error together is an error; responses while idle are ignored
        setup_wait();
        f_lat  = 2;
        f_kind = 2;
        new_d();
        drain();
        idle_noise = 1;
        repeat (8) step();
        idle_noise = 0;

        // Reset in the middle of a data access with m_ack asserted
        setup_wait();
        f_lat            = 100;
        bus_if.d_access  = 1'b1;
        bus_if.d_addr    = 32'h0000_0200;
        bus_if.d_bytesel = 4'h5;
        bus_if.d_wr_en   = 1'b1;
        bus_if.d_wr_val  = 32'hcafe_f00d;
        start = 0;
        while (!(owner == OWN_D && busy_cyc == 2) && start < 20) begin
            step();
            start++;
        end
        chk("mid_rst_reached_busy", 64'(owner), 64'(OWN_D));
        @(negedge clk);
        bus_if.m_ack    = 1'b1;
        bus_if.m_error  = 1'b0;
        rst_n           = 1'b0;
        bus_if.d_access = 1'b0;
        new_i();
        #1;
        chk("mid_rst_d_ack", 64'(bus_if.d_ack), 64'd0);
        chk("mid_rst_d_error", 64'(bus_if.d_error), 64'd0);
        chk("mid_rst_m_access", 64'(bus_if.m_access), 64'd0);
        chk("mid_rst_m_addr", 64'(bus_if.m_addr), 64'd0);
        chk("mid_rst_m_wr_val", 64'(bus_if.m_wr_val), 64'd0);
        chk("mid_rst_m_wr_en", 64'(bus_if.m_wr_en), 64'd0);
        owner    = OWN_NONE;
        last     = OWN_I;
        busy_cyc = 0;
        done_i   = 0;
        done_d   = 0;
        @(posedge clk);
        #2;
        rst_n  = 1'b1;
        f_lat  = 2;
        f_kind = 0;
        drain();

        // Randomised traffic
        setup_wait();
        f_lat      = -1;
        f_kind     = -1;
        rand_mode  = 1;
        idle_noise = 1;
        repeat (3000) step();
        rand_mode  = 0;
        idle_noise = 0;
        drain();

        chk("req_queue_empty", 64'(exp_req.size()), 64'd0);
        chk("resp_queue_empty", 64'(exp_resp.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/oldland_bus_arbiter.md
OLDLAND_BUS_ARBITER -- requirements
Module: oldland_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: busy cycles without m_ack/m_error before abort; legal range 1..65535.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port i_access  in  1  instruction fetch request, held until i_ack/i_error.
REQ-006 SHALL have port i_addr  in  32  instruction fetch address.
REQ-007 SHALL have ports i_data  out  32, i_ack  out  1 and i_error  out  1: fetch read data, completion pulse and error pulse.
REQ-008 SHALL have port d_access  in  1  data request, held until d_ack/d_error.
REQ-009 SHALL have ports d_addr  in  32, d_bytesel  in  4, d_wr_en  in  1 and d_wr_val  in  32: data request fields.
REQ-010 SHALL have ports d_data  out  32, d_ack  out  1 and d_error  out  1: data read data, completion pulse and error pulse.
REQ-011 SHALL have ports m_access  out  1, m_addr  out  32, m_bytesel  out  4, m_wr_en  out  1 and m_wr_val  out  32: shared memory port request.
REQ-012 SHALL have ports m_data  in  32, m_ack  in  1 and m_error  in  1: shared memory port response.

Function
REQ-013 SHALL implement FSM states IDLE, I_BUSY and D_BUSY.
REQ-014 IDLE with one access high SHALL enter that requester's BUSY state on the next edge.
REQ-015 IDLE with both high SHALL grant the requester not granted last; last_grant resets to I, so data wins the first tie.
REQ-016 On the grant edge, the arbiter SHALL register m_addr/m_bytesel/m_wr_en/m_wr_val from the granted port and set m_access=1; m_access is high from the cycle after the request is sampled.
REQ-017 In I_BUSY, m_wr_en SHALL be 0 and m_bytesel SHALL be 4'hf.
REQ-018 i_data and d_data SHALL both be combinational copies of m_data.
REQ-019 In a BUSY state, m_ack/m_error SHALL route combinationally, same cycle, to the granted requester's ack/error only; the other requester sees 0.
REQ-020 On the completion edge, the arbiter SHALL enter the other requester's BUSY state if that requester's access is high (back-to-back, no idle cycle, m_access stays 1 with new fields); otherwise IDLE with m_access=0.
REQ-021 The just-completed requester SHALL NOT be regranted on its completion edge.
REQ-022 A busy counter SHALL clear on every grant and increment each BUSY cycle without response; its width SHALL be clog2(TIMEOUT_CYCLES+1).
REQ-023 When the counter equals TIMEOUT_CYCLES with no response, the arbiter SHALL pulse the granted requester's error for 1 cycle, drop m_access and go to IDLE.
REQ-024 If m_ack or m_error is high in the timeout cycle, the real response SHALL win and no timeout error is generated.
REQ-025 m_ack and m_error high together SHALL be treated as error: ack suppressed, error passed.
REQ-026 m_ack/m_error in IDLE SHALL be ignored.
REQ-027 Requester deassertion of access mid-transaction is illegal; the arbiter SHALL continue until response or timeout.
REQ-028 last_grant SHALL update on every grant.

Reset
REQ-029 While rst_n=0 (asynchronous), the block SHALL be in IDLE with m_access=0, m_addr/m_bytesel/m_wr_en/m_wr_val=0, counter=0 and last_grant=I.
REQ-030 i_ack/i_error/d_ack/d_error SHALL be 0 during reset regardless of m_ack/m_error.
REQ-031 Reset mid-transaction SHALL abandon the transaction with no ack or error to either requester; the first grant after release follows REQ-014/REQ-015.

Structure
REQ-032 State encoding, grant identifiers (GRANT_I, GRANT_D) and the default timeout constant SHALL live in shared package/include oldland_bus_defs.
REQ-033 The timeout counter SHALL be one sub-module, oldland_bus_timeout (inputs clear, enable; output expired), parameterised by TIMEOUT_CYCLES.

Verification
REQ-034 The bench SHALL cover: d_access=1, addr 0x100, wr_en=1, val 0xdeadbeef, m_ack at 3rd busy cycle -> m_access next cycle with m_addr 0x100, m_wr_val 0xdeadbeef; d_ack same cycle as m_ack; i_ack never.
REQ-035 The bench SHALL cover: i_access and d_access rise together after reset -> D granted first, then I back-to-back on D's ack edge (m_access continuous, m_addr switches to i_addr, m_bytesel 4'hf, m_wr_en 0).
REQ-036 The bench SHALL cover: both held continuously for 6 transactions, m_ack each 2nd cycle -> grants alternate D,I,D,I,D,I.
REQ-037 The bench SHALL cover: TIMEOUT_CYCLES=4, i_access with no m_ack -> i_error pulses 1 cycle on the 4th busy cycle, m_access low next cycle, then IDLE; a variant with m_ack in that same cycle gives i_ack and no i_error.
REQ-038 The bench SHALL cover: rst_n low mid-D_BUSY with m_ack asserted -> outputs zero immediately, no d_ack; after release with i_access high -> I granted.
REQ-039 The bench SHALL cover: m_ack and m_error together in D_BUSY -> d_error=1 and d_ack=0; m_ack in IDLE -> no ack outputs.
